psw_stack_register: RTL and testbench

Processor status word (PSW) register with a hardware context stack for nested traps. It is the parametrised successor of the single-level status register in the X-Makina multi-cycle core. It keeps the same field layout and write modes. It adds a DEPTH-entry stack that saves the full PSW on trap entry and restores it on trap return, with full/empty tracking and overflow/underflow reporting. It sits in the control path between the control unit (trap sequencing, flag updates) and the register file/bus (PSW read/write).

---
 rtl/psw_stack_register.sv | 111 +++++++++++
 tb/tb_psw_stack_register.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/psw_stack_register.sv
// psw_stack_register: processor status word with a DEPTH-entry trap context stack.
// Optional PSW_DEPTH_IN_RES_EN shows the stack depth in the LSBs of the res field.
module psw_stack_register #(
    parameter int WORD  = 16,
    parameter int FLAGS = 4,
    parameter int PLVLS = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(PLVLS),
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              trapEntry_i,
    input  logic [PW-1:0]     trapPriv_i,
    input  logic              trapRet_i,
    input  logic              WrEn_i,
    input  logic [WORD/8-1:0] wrMode_i,
    input  logic [WORD-1:0]   data_i,
    input  logic              flagsWr_i,
    input  logic [FLAGS-1:0]  flagsEn_i,
    input  logic [FLAGS-1:0]  flags_i,
    input  logic              clrSlp_i,
    output logic [WORD-1:0]   data_o,
    output logic [FLAGS-1:0]  flags_o,
    output logic              slp_o,
    output logic              ie_o,
    output logic [PW-1:0]     currPriv_o,
    output logic [PW-1:0]     prevPriv_o,
    output logic [DW-1:0]     depth_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              ovf_o,
    output logic              unf_o
);
    localparam int RW = WORD - 2 * PW - FLAGS - 2;

    logic [WORD-1:0] stack [DEPTH];
    logic [WORD-1:0] top;
    logic [RW-1:0]   res;
    logic [1:0]      md;
    logic            unused;

`ifdef PSW_DEPTH_IN_RES_EN
    assign res = RW'(depth_o);
    if (DW > RW) begin : g_res_chk
        $error("psw_stack_register: depth does not fit in the res field");
    end
`else
    assign res = '0;
`endif

    assign md      = 2'(wrMode_i);
    assign data_o  = {currPriv_o, prevPriv_o, res, ie_o, slp_o, flags_o};
    assign full_o  = depth_o == DW'(DEPTH);
    assign empty_o = depth_o == '0;
    assign unused  = ^{data_i, top};

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) top = (depth_o == DW'(i + 1)) ? stack[i] : top;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            flags_o    <= '0;
            slp_o      <= 1'b0;
            ie_o       <= 1'b0;
            currPriv_o <= '0;
            prevPriv_o <= '0;
            depth_o    <= '0;
            ovf_o      <= 1'b0;
            unf_o      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else begin
            ovf_o <= trapEntry_i && full_o;
            unf_o <= !trapEntry_i && trapRet_i && empty_o;
            if (trapEntry_i) begin
                if (!full_o) begin
                    for (int i = 0; i < DEPTH; i++) if (depth_o == DW'(i)) stack[i] <= data_o;
                    depth_o    <= depth_o + DW'(1);
                    currPriv_o <= trapPriv_i;
                    prevPriv_o <= currPriv_o;
                    ie_o       <= 1'b0;
                    slp_o      <= 1'b0;
                end
            end else if (trapRet_i) begin
                if (!empty_o) begin
                    depth_o    <= depth_o - DW'(1);
                    flags_o    <= top[FLAGS-1:0];
                    slp_o      <= top[FLAGS];
                    ie_o       <= top[FLAGS+1];
                    prevPriv_o <= top[WORD-PW-1 -: PW];
                    currPriv_o <= top[WORD-1 -: PW];
                end
            end else if (WrEn_i) begin
                if (md[0]) begin
                    flags_o <= data_i[FLAGS-1:0];
                    slp_o   <= data_i[FLAGS];
                    ie_o    <= data_i[FLAGS+1];
                end
                if (md[1]) begin
                    prevPriv_o <= data_i[WORD-PW-1 -: PW];
                    currPriv_o <= data_i[WORD-1 -: PW];
                end
            end else begin
                if (clrSlp_i) slp_o <= 1'b0;
                if (flagsWr_i) flags_o <= (flags_o & ~flagsEn_i) | (flags_i & flagsEn_i);
            end
        end
    end
endmodule

// File: tb/tb_psw_stack_register.sv
// tb_psw_stack_register: directed and random checks against a field/queue model of the PSW stack.
module tb_psw_stack_register;
    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        trapEntry_i, trapRet_i, WrEn_i, flagsWr_i, clrSlp_i;
    logic [2:0]  trapPriv_i;
    logic [1:0]  wrMode_i;
    logic [15:0] data_i;
    logic [3:0]  flagsEn_i, flags_i;
    logic [15:0] data_o;
    logic [3:0]  flags_o;
    logic        slp_o, ie_o, full_o, empty_o, ovf_o, unf_o;
    logic [2:0]  currPriv_o, prevPriv_o, depth_o;

`ifdef PSW_DEPTH_IN_RES_EN
    localparam bit RES_EN = 1'b1;
`else
    localparam bit RES_EN = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    int m_flags, m_slp, m_ie, m_curr, m_prev, m_ovf, m_unf;
    logic [15:0] q[$];
    logic [15:0] saved;

    always #5 clk_i = ~clk_i;

    psw_stack_register dut (
        .clk_i(clk_i), .arst_i(arst_i), .trapEntry_i(trapEntry_i), .trapPriv_i(trapPriv_i),
        .trapRet_i(trapRet_i), .WrEn_i(WrEn_i), .wrMode_i(wrMode_i), .data_i(data_i),
        .flagsWr_i(flagsWr_i), .flagsEn_i(flagsEn_i), .flags_i(flags_i), .clrSlp_i(clrSlp_i),
        .data_o(data_o), .flags_o(flags_o), .slp_o(slp_o), .ie_o(ie_o),
        .currPriv_o(currPriv_o), .prevPriv_o(prevPriv_o), .depth_o(depth_o),
        .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o), .unf_o(unf_o)
    );

    function automatic logic [15:0] m_psw();
        int res = RES_EN ? q.size() : 0;
        return 16'(m_curr * 8192 + m_prev * 1024 + res * 64 + m_ie * 32 + m_slp * 16 + m_flags);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        {m_flags, m_slp, m_ie, m_curr, m_prev, m_ovf, m_unf} = '0;
        q.delete();
    endtask

    task automatic m_step();
        logic [15:0] w;
        m_ovf = 0;
        m_unf = 0;
        if (trapEntry_i) begin
            if (q.size() == 4) m_ovf = 1;
            else begin
                q.push_back(m_psw());
                m_prev = m_curr;
                m_curr = trapPriv_i;
                m_ie   = 0;
                m_slp  = 0;
            end
        end else if (trapRet_i) begin
            if (q.size() == 0) m_unf = 1;
            else begin
                w       = q.pop_back();
                m_flags = w % 16;
                m_slp   = (w / 16) % 2;
                m_ie    = (w / 32) % 2;
                m_prev  = (w / 1024) % 8;
                m_curr  = w / 8192;
            end
        end else if (WrEn_i) begin
            if (wrMode_i[0]) begin
                m_flags = data_i % 16;
                m_slp   = (data_i / 16) % 2;
                m_ie    = (data_i / 32) % 2;
            end
            if (wrMode_i[1]) begin
                m_prev = (data_i / 1024) % 8;
                m_curr = data_i / 8192;
            end
        end else begin
            if (clrSlp_i) m_slp = 0;
            if (flagsWr_i)
                for (int i = 0; i < 4; i++)
                    if (flagsEn_i[i]) m_flags = flags_i[i] ? (m_flags | (1 << i)) : (m_flags & ~(1 << i));
        end
    endtask

    task automatic check_all();
        check("data_o", data_o, m_psw());
        check("depth_o", depth_o, q.size());
        check("full_o", full_o, q.size() == 4);
        check("empty_o", empty_o, q.size() == 0);
        check("ovf_o", ovf_o, m_ovf);
        check("unf_o", unf_o, m_unf);
        check("flags_o", flags_o, m_flags);
        check("slp_o", slp_o, m_slp);
        check("ie_o", ie_o, m_ie);
        check("curr", currPriv_o, m_curr);
        check("prev", prevPriv_o, m_prev);
    endtask

    task automatic idle();
        {trapEntry_i, trapRet_i, WrEn_i, flagsWr_i, clrSlp_i} = '0;
        {trapPriv_i, wrMode_i, data_i, flagsEn_i, flags_i} = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        m_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        arst_i = 1'b1;
        #2;
        m_reset();
        check_all();
        check("rst_data", data_o, 0);
        check("rst_empty", empty_o, 1);
        arst_i = 1'b0;
    endtask

    initial begin
        idle();
        do_reset();
        // bus write of the full PSW
        WrEn_i = 1; wrMode_i = 2'b11; data_i = 16'h4425;
        tick(); idle();
        check("tp_wr", data_o, 16'h4425);
        trapEntry_i = 1; trapPriv_i = 3'd7;
        tick(); idle();
        check("tp_push", data_o, 16'hE805 | (RES_EN ? 16'h0040 : 16'h0));
        trapRet_i = 1;
        tick(); idle();
        check("tp_pop", data_o, 16'h4425);
        // fill past full, then drain past empty
        saved = data_o;
        for (int i = 0; i < 5; i++) begin
            trapEntry_i = 1; trapPriv_i = 3'(i + 3);
            tick();
            if (i == 3) check("tp_full", full_o, 1);
            if (i == 4) check("tp_ovf", ovf_o, 1);
        end
        idle(); tick();
        check("tp_ovf_clr", ovf_o, 0);
        for (int i = 0; i < 5; i++) begin
            trapRet_i = 1;
            tick();
            if (i == 4) check("tp_unf", unf_o, 1);
        end
        idle(); tick();
        check("tp_lifo", data_o, saved);
        check("tp_unf_clr", unf_o, 0);
        // push wins over return and write in the same cycle
        trapEntry_i = 1; trapRet_i = 1; WrEn_i = 1; wrMode_i = 2'b11; data_i = 16'hFFFF; trapPriv_i = 3'd1;
        tick(); idle();
        check("tp_prio", depth_o, 1);
        WrEn_i = 1; wrMode_i = 2'b01; data_i = 16'h0010;
        tick(); idle();
        flagsWr_i = 1; flagsEn_i = 4'b1010; flags_i = 4'b1111; clrSlp_i = 1;
        tick(); idle();
        check("tp_flags", flags_o, 4'b1010);
        check("tp_slp", slp_o, 0);
        trapEntry_i = 1;
        repeat (2) tick();
        idle();
        check("tp_res", data_o[9:6], RES_EN ? 4'd3 : 4'd0);
        // random traffic with alternating push-heavy and pop-heavy phases
        for (int n = 0; n < 3000; n++) begin
            int pe = ((n / 40) % 2) ? 1 : 4;
            int pr = ((n / 40) % 2) ? 4 : 1;
            trapEntry_i = $urandom_range(pe) == 0;
            trapRet_i   = $urandom_range(pr) == 0;
            WrEn_i      = $urandom_range(2) == 0;
            trapPriv_i  = 3'($urandom);
            wrMode_i    = 2'($urandom);
            data_i      = 16'($urandom);
            flagsWr_i   = 1'($urandom);
            flagsEn_i   = 4'($urandom);
            flags_i     = 4'($urandom);
            clrSlp_i    = 1'($urandom);
            tick();
            if ($urandom_range(299) == 0) do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
